// File: rtl/accum_pkg.sv
// Shared definitions for the product accumulator: FSM state encoding,
// default widths and the fixed product width from the 8x8 multiplier.
// The saturation option is selected with the ACCUM_SAT_EN macro in sat_add_2sc.
package accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int ACC_W_DEF = 18;
  localparam int LEN_W_DEF = 4;
  localparam int PROD_W    = 16;

endpackage

// File: rtl/sat_add_2sc.sv
// Combinational two's-complement add of a 16-bit product onto the accumulator.
// Reports overflow of the true sum against the ACC_W range. With ACCUM_SAT_EN
// defined the result clamps to the range limits; otherwise it wraps.
module sat_add_2sc
  import accum_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0]  a,
  input  logic signed [PROD_W-1:0] b,
  output logic signed [ACC_W-1:0]  sum,
  output logic                     ovf
);

  localparam logic [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};

  // One guard bit is enough: ACC_W >= 17 so the product always fits in ACC_W.
  logic [ACC_W:0] full;

  // Exact sum in ACC_W+1 bits; overflow when the top two bits disagree.
  always_comb begin
    full = {a[ACC_W-1], a} + {{(ACC_W+1-PROD_W){b[PROD_W-1]}}, b};
    ovf  = full[ACC_W] ^ full[ACC_W-1];
`ifdef ACCUM_SAT_EN
    if (ovf) begin
      sum = full[ACC_W] ? MIN_V : MAX_V;
    end else begin
      sum = full[ACC_W-1:0];
    end
`else
    sum = full[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/accum_prod_2sc.sv
// Frame accumulator for signed 16-bit multiplier products.
// A start pulse opens a frame of len products (0 means 2^LEN_W); each valid
// product is added into acc, and acc_vld pulses for one cycle in DONE.
// Build option: ACCUM_SAT_EN (saturating rather than wrapping accumulation).
module accum_prod_2sc
  import accum_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [PROD_W-1:0] y_in,
  input  logic                     y_vld,
  input  logic                     start,
  input  logic [LEN_W-1:0]         len,
  output logic signed [ACC_W-1:0]  acc,
  output logic                     acc_vld,
  output logic                     busy,
  output logic                     ovf
);

  // One extra bit so a full 2^LEN_W frame can be counted.
  localparam logic [LEN_W:0] CNT_ONE  = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [LEN_W:0] CNT_FULL = {1'b1, {LEN_W{1'b0}}};

  state_t                  state_reg, state_next;
  logic signed [ACC_W-1:0] acc_reg, acc_next;
  logic [LEN_W:0]          cnt_reg, cnt_next;
  logic                    ovf_reg, ovf_next;
  logic                    busy_reg, busy_next;
  logic                    vld_reg, vld_next;

  logic signed [ACC_W-1:0] add_sum;
  logic                    add_ovf;

  sat_add_2sc #(
    .ACC_W(ACC_W)
  ) u_add (
    .a  (acc_reg),
    .b  (y_in),
    .sum(add_sum),
    .ovf(add_ovf)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath and output registers; outputs never see inputs combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_reg  <= '0;
      cnt_reg  <= '0;
      ovf_reg  <= 1'b0;
      busy_reg <= 1'b0;
      vld_reg  <= 1'b0;
    end else begin
      acc_reg  <= acc_next;
      cnt_reg  <= cnt_next;
      ovf_reg  <= ovf_next;
      busy_reg <= busy_next;
      vld_reg  <= vld_next;
    end
  end

  // Next-state and next-datapath logic; y_vld and start only matter where used.
  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    ovf_next   = ovf_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = ACCUM;
          acc_next   = '0;
          ovf_next   = 1'b0;
          cnt_next   = (len == '0) ? CNT_FULL : {1'b0, len};
        end
      end
      ACCUM: begin
        if (y_vld) begin
          acc_next = add_sum;
          ovf_next = ovf_reg | add_ovf;
          cnt_next = cnt_reg - CNT_ONE;
          if (cnt_reg == CNT_ONE) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    busy_next = (state_next != IDLE);
    vld_next  = (state_next == DONE);
  end

  assign acc     = acc_reg;
  assign acc_vld = vld_reg;
  assign busy    = busy_reg;
  assign ovf     = ovf_reg;

endmodule

// File: tb/tb_accum_prod_2sc.sv
// Self-checking bench for accum_prod_2sc: a frame-level reference model
// (integer sum, explicit range folding) is compared against the DUT every
// cycle, with directed frames pinning known sums and random frames for breadth.
// Honours ACCUM_SAT_EN the same way the design does.
module tb_accum_prod_2sc;

  localparam int     ACC_W = 18;
  localparam int     LEN_W = 4;
  localparam longint MAX_V = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint MIN_V = -(longint'(1) <<< (ACC_W - 1));
  localparam longint MODV  = longint'(1) <<< ACC_W;

  logic                    clk   = 1'b0;
  logic                    reset = 1'b0;
  logic signed [15:0]      y_in  = '0;
  logic                    y_vld = 1'b0;
  logic                    start = 1'b0;
  logic [LEN_W-1:0]        len   = '0;
  logic signed [ACC_W-1:0] acc;
  logic                    acc_vld;
  logic                    busy;
  logic                    ovf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  accum_prod_2sc #(
    .ACC_W(ACC_W),
    .LEN_W(LEN_W)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .y_in   (y_in),
    .y_vld  (y_vld),
    .start  (start),
    .len    (len),
    .acc    (acc),
    .acc_vld(acc_vld),
    .busy   (busy),
    .ovf    (ovf)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bring an exact sum back into the accumulator range.
  function automatic longint fold(input longint t);
    longint r;
`ifdef ACCUM_SAT_EN
    r = t;
    if (t > MAX_V) r = MAX_V;
    if (t < MIN_V) r = MIN_V;
`else
    r = t % MODV;
    if (r > MAX_V) r = r - MODV;
    else if (r < MIN_V) r = r + MODV;
`endif
    return r;
  endfunction

  // Reference model: frame open flag, products left, running sum, sticky ovf.
  longint m_sum    = 0;
  bit     m_active = 0;
  bit     m_done   = 0;
  bit     m_ovf    = 0;
  int     m_left   = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_sum = 0; m_active = 0; m_done = 0; m_ovf = 0; m_left = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1;
        m_sum    = 0;
        m_ovf    = 0;
        m_left   = (len == 0) ? (1 << LEN_W) : int'(len);
      end
    end else if (y_vld) begin
      if (m_sum + longint'(y_in) > MAX_V || m_sum + longint'(y_in) < MIN_V) m_ovf = 1;
      m_sum  = fold(m_sum + longint'(y_in));
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_active = 0;
        m_done   = 1;
      end
    end
  end

  // Per-cycle comparison against the model, plus acc_vld pulse bookkeeping.
  int     vld_pulses = 0;
  longint vld_acc    = 0;
  longint vld_ovf    = 0;

  always @(negedge clk) begin
    check("acc", longint'(acc), m_sum);
    check("acc_vld", longint'(acc_vld), longint'(m_done));
    check("busy", longint'(busy), longint'(m_active | m_done));
    check("ovf", longint'(ovf), longint'(m_ovf));
    if (acc_vld) begin
      vld_pulses++;
      vld_acc = longint'(acc);
      vld_ovf = longint'(ovf);
    end
  end

  // All stimulus tasks start and finish at a falling edge.
  task automatic start_frame(input int l, input bit junk_vld);
    start = 1'b1;
    len   = LEN_W'(l);
    y_vld = junk_vld;
    y_in  = 16'sd1234;
    @(negedge clk);
    start = 1'b0;
    y_vld = 1'b0;
  endtask

  task automatic push(input int v, input int gap);
    y_in  = 16'(v);
    y_vld = 1'b1;
    @(negedge clk);
    y_vld = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Wait (bounded) for the frame's acc_vld pulse and pin its literal result.
  task automatic wait_done(input string name, input int p0, input longint exp_acc,
                           input longint exp_ovf);
    int k;
    k = 0;
    while (vld_pulses == p0 && k < 64) begin
      @(posedge clk);
      k++;
    end
    if (vld_pulses == p0) begin
      check({name, "_pulse_seen"}, longint'(vld_pulses - p0), 1);
    end else begin
      check({name, "_acc"}, vld_acc, exp_acc);
      check({name, "_ovf"}, vld_ovf, exp_ovf);
      @(negedge clk);
      check({name, "_busy_fall"}, longint'(busy), 0);
      repeat (3) @(negedge clk);
      check({name, "_one_pulse"}, longint'(vld_pulses - p0), 1);
    end
  endtask

  initial begin
    int p0;
    int l;
    int n;
    int got;
    repeat (3) @(negedge clk);
    check("rst_acc", longint'(acc), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_vld", longint'(acc_vld), 0);
    check("rst_ovf", longint'(ovf), 0);
    reset = 1'b1;
    @(negedge clk);

    // Small frame with gaps.
    p0 = vld_pulses;
    start_frame(4, 1'b0);
    push(100, 2); push(-50, 1); push(25, 3); push(3, 0);
    wait_done("len4", p0, 78, 0);

    // Full-length frame overflowing upward.
    p0 = vld_pulses;
    start_frame(0, 1'b0);
    for (int i = 0; i < 16; i++) push(16384, 0);
`ifdef ACCUM_SAT_EN
    wait_done("ovf_pos", p0, 131071, 1);
`else
    wait_done("ovf_pos", p0, 0, 1);
`endif

    // Full-length frame overflowing downward.
    p0 = vld_pulses;
    start_frame(0, 1'b0);
    for (int i = 0; i < 16; i++) push(-16256, 1);
    repeat (0) @(negedge clk);
`ifdef ACCUM_SAT_EN
    wait_done("ovf_neg", p0, -131072, 1);
`else
    wait_done("ovf_neg", p0, 2048, 1);
`endif

    // Ignored inputs: y_vld with start, start mid-frame, y_vld and start in DONE.
    p0 = vld_pulses;
    start_frame(3, 1'b1);
    push(10, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    push(20, 0);
    push(30, 0);
    y_in  = 16'sd500;
    y_vld = 1'b1;
    start = 1'b1;
    @(negedge clk);
    y_vld = 1'b0;
    start = 1'b0;
    wait_done("ignore", p0, 60, 0);

    // Asynchronous reset mid-frame.
    p0 = vld_pulses;
    start_frame(4, 1'b0);
    push(11, 1); push(22, 0);
    #2 reset = 1'b0;
    #1;
    check("arst_acc", longint'(acc), 0);
    check("arst_busy", longint'(busy), 0);
    check("arst_vld", longint'(acc_vld), 0);
    check("arst_ovf", longint'(ovf), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("arst_no_pulse", longint'(vld_pulses - p0), 0);
    check("arst_idle", longint'(busy), 0);
    p0 = vld_pulses;
    start_frame(1, 1'b0);
    push(-7, 0);
    wait_done("after_rst", p0, -7, 0);

    // Random frames, checked cycle by cycle against the model.
    for (int f = 0; f < 24; f++) begin
      p0 = vld_pulses;
      l  = int'($urandom_range(0, 15));
      n  = (l == 0) ? 16 : l;
      start_frame(l, 1'($urandom_range(0, 1)));
      got = 0;
      while (got < n) begin
        if ($urandom_range(0, 3) != 0) begin
          if ($urandom_range(0, 1) != 0) y_in = 16'($urandom);
          else y_in = 16'(int'($urandom_range(0, 400)) - 200);
          y_vld = 1'b1;
          got++;
        end else begin
          y_vld = 1'b0;
          start = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        y_vld = 1'b0;
        start = 1'b0;
      end
      n = 0;
      while (vld_pulses == p0 && n < 64) begin
        @(negedge clk);
        n++;
      end
      repeat (2) @(negedge clk);
      check("rand_one_pulse", longint'(vld_pulses - p0), 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
